flit_sink: RTL

- Receive-side endpoint of the flit link (idata/ivalid/ivch) driven by the mux under characterization.
- Consumes flits, checks HEAD/DATA/TAIL framing per packet and records per-packet length, destination and VC.
- Accumulates link-utilization and payload bit-toggle statistics for the energy benches.
- Sits directly on a mux output port, in benches and in the router.

---
 rtl/flit_sink.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/flit_sink.sv
// flit_sink: receive endpoint of the flit link.
// Checks HEAD/DATA/TAIL framing, records the last completed packet's
// length/dest/VC, and accumulates utilization statistics.
// Optional: define FLIT_SINK_TOGGLE_EN to accumulate the payload Hamming
// distance between consecutive valid flits in toggle_cnt (0 otherwise).
module flit_sink #(
    parameter int unsigned FLIT_W = 66,
    parameter int unsigned VCH_W  = 2,
    parameter int unsigned CNT_W  = 32,
    parameter int unsigned LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FLIT_W-1:0] idata,
    input  logic              ivalid,
    input  logic [VCH_W-1:0]  ivch,
    input  logic              clr,
    output logic              busy,
    output logic              pkt_done,
    output logic [LEN_W-1:0]  last_len,
    output logic [31:0]       last_dest,
    output logic [VCH_W-1:0]  last_vch,
    output logic [CNT_W-1:0]  pkt_cnt,
    output logic [CNT_W-1:0]  flit_cnt,
    output logic [CNT_W-1:0]  cyc_cnt,
    output logic [CNT_W-1:0]  toggle_cnt,
    output logic              err,
    output logic [2:0]        err_code
);

    typedef enum logic {IDLE, BODY} state_t;
    typedef enum logic [1:0] {F_NONE = 2'b00, F_HEAD = 2'b01, F_TAIL = 2'b10, F_DATA = 2'b11} ftype_t;

    state_t             state, state_next;
    ftype_t             ftype;
    logic [2:0]         code_now;
    logic               start_head, count_data, accept_tail;

    logic [LEN_W-1:0]   cur_len;
    logic [31:0]        dest_q;
    logic [VCH_W-1:0]   vch_q;

    logic [CNT_W-1:0]   pkt_base, flit_base, cyc_base;
    logic [CNT_W-1:0]   pkt_next, flit_next, cyc_next;
    logic               err_base, err_next;
    logic [2:0]         code_base, code_next;

    assign ftype = ftype_t'(idata[FLIT_W-1 -: 2]);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next state and per-cycle event decode; code_now holds the lowest error code seen
    always_comb begin
        state_next  = state;
        code_now    = '0;
        start_head  = 1'b0;
        count_data  = 1'b0;
        accept_tail = 1'b0;
        if (ivalid) begin
            unique case (ftype)
                F_NONE: code_now = 3'd4;
                F_HEAD: begin
                    start_head = 1'b1;
                    state_next = BODY;
                    if (state == BODY) code_now = 3'd2;
                end
                F_DATA: begin
                    if (state == BODY) count_data = 1'b1;
                    else               code_now   = 3'd1;
                end
                F_TAIL: begin
                    if (state == BODY) begin
                        accept_tail = 1'b1;
                        state_next  = IDLE;
                    end else begin
                        code_now = 3'd1;
                    end
                end
            endcase
            if ((state == BODY) && (ivch != vch_q) && ((code_now == 3'd0) || (code_now > 3'd3)))
                code_now = 3'd3;
        end
    end

    // Statistics next values: clr zeroes the base first, then this cycle's events apply
    always_comb begin
        pkt_base  = clr ? '0 : pkt_cnt;
        flit_base = clr ? '0 : flit_cnt;
        cyc_base  = clr ? '0 : cyc_cnt;
        err_base  = clr ? 1'b0 : err;
        code_base = clr ? '0 : err_code;

        cyc_next  = (cyc_base == '1) ? cyc_base : cyc_base + CNT_W'(1);
        flit_next = flit_base;
        if (ivalid && (flit_base != '1)) flit_next = flit_base + CNT_W'(1);
        pkt_next  = pkt_base;
        if (accept_tail && (pkt_base != '1)) pkt_next = pkt_base + CNT_W'(1);

        err_next  = err_base;
        code_next = code_base;
        if (!err_base && (code_now != 3'd0)) begin
            err_next  = 1'b1;
            code_next = code_now;
        end
    end

    // Packet tracking, last-packet record and counters
    always_ff @(posedge clk) begin
        if (rst) begin
            busy      <= 1'b0;
            pkt_done  <= 1'b0;
            cur_len   <= '0;
            dest_q    <= '0;
            vch_q     <= '0;
            last_len  <= '0;
            last_dest <= '0;
            last_vch  <= '0;
            pkt_cnt   <= '0;
            flit_cnt  <= '0;
            cyc_cnt   <= '0;
            err       <= 1'b0;
            err_code  <= '0;
        end else begin
            busy     <= (state_next == BODY);
            pkt_done <= accept_tail;
            if (start_head) begin
                cur_len <= '0;
                dest_q  <= idata[31:0];
                vch_q   <= ivch;
            end else if (count_data && (cur_len != '1)) begin
                cur_len <= cur_len + LEN_W'(1);
            end
            if (accept_tail) begin
                last_len  <= cur_len;
                last_dest <= dest_q;
                last_vch  <= vch_q;
            end
            pkt_cnt  <= pkt_next;
            flit_cnt <= flit_next;
            cyc_cnt  <= cyc_next;
            err      <= err_next;
            err_code <= code_next;
        end
    end

`ifdef FLIT_SINK_TOGGLE_EN
    logic [63:0]      prev_payload, prev_base;
    logic [CNT_W-1:0] tog_base, tog_next;
    logic [CNT_W:0]   tog_sum;
    logic [6:0]       hdist;

    // Hamming distance of this payload against the previous one (0 after rst/clr)
    always_comb begin
        prev_base = clr ? '0 : prev_payload;
        tog_base  = clr ? '0 : toggle_cnt;
        hdist     = 7'($countones(idata[63:0] ^ prev_base));
        tog_sum   = {1'b0, tog_base} + (CNT_W+1)'(hdist);
        tog_next  = tog_base;
        if (ivalid) tog_next = tog_sum[CNT_W] ? '1 : tog_sum[CNT_W-1:0];
    end

    // Toggle accumulator and previous-payload register
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_payload <= '0;
            toggle_cnt   <= '0;
        end else begin
            prev_payload <= ivalid ? idata[63:0] : prev_base;
            toggle_cnt   <= tog_next;
        end
    end
`else
    assign toggle_cnt = '0;
`endif

endmodule
